vco_adc_seq: RTL and testbench
==============================

VCO_ADC_SEQ -- requirements
Module: vco_adc_seq

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width of the phase-edge counter and of sample_o.
REQ-002 The block SHALL have parameter OSR_W, default 10: width of oversample_i.
REQ-003 The block SHALL have input wb_clk_i, 1 bit: the single clock.
REQ-004 The block SHALL have input wb_rst_n, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have input start_i, 1 bit: single-cycle pulse that begins a conversion run.
REQ-006 The block SHALL have input stop_i, 1 bit: single-cycle pulse that aborts the current run.
REQ-007 The block SHALL have input cont_i, 1 bit: 1 selects continuous windows, 0 selects a single window.
REQ-008 The block SHALL have input oversample_i, OSR_W bits: window length in clocks; the value 0 is treated as 1.
REQ-009 The block SHALL have input warmup_i, 8 bits: VCO settle time in clocks.
REQ-010 The block SHALL have input phase_in, 1 bit: VCO phase, asynchronous to wb_clk_i.
REQ-011 The block SHALL have output vco_enb_o, 1 bit: VCO enable, active-low.
REQ-012 The block SHALL have output sample_o, CNT_W bits: phase-edge count for one window.
REQ-013 The block SHALL have output sample_valid_o, 1 bit, and input sample_ready_i, 1 bit: valid/ready handshake for sample_o.
REQ-014 The block SHALL have output busy_o, 1 bit: high whenever the FSM is not in IDLE.
REQ-015 The block SHALL have output overrun_o, 1 bit (sticky), and input clr_overrun_i, 1 bit, which clears it.

Function
REQ-016 phase_in SHALL pass through a 2-flop synchronizer; a rising-edge detect on the synchronized signal SHALL produce a one-clock edge pulse.
REQ-017 The FSM SHALL have states IDLE, WARMUP and CONVERT.
REQ-018 In IDLE, start_i SHALL latch oversample_i, warmup_i and cont_i, and SHALL move the FSM to WARMUP.
REQ-019 In WARMUP, vco_enb_o SHALL be 0; after exactly warmup_i clocks the FSM SHALL enter CONVERT; warmup_i=0 SHALL give one WARMUP clock.
REQ-020 In CONVERT, vco_enb_o SHALL be 0, and each window SHALL last exactly N = max(latched oversample,1) clocks.
REQ-021 During a window, edge pulses SHALL increment the counter, saturating at 2^CNT_W-1.
REQ-022 In the last window clock, the count, including any edge pulse in that clock, SHALL be offered to the output register.
REQ-023 When the output register is offered a count: if sample_valid_o=0 or sample_ready_i=1 in that cycle, sample_o SHALL be loaded and sample_valid_o SHALL be 1 on the next clock.
REQ-024 Otherwise (sample_valid_o=1 and sample_ready_i=0), the new count SHALL be dropped, sample_o SHALL be held, and overrun_o SHALL be set.
REQ-025 With cont_i latched at 1, the next window SHALL start in the following clock with the counter at 0, with no gap.
REQ-026 With cont_i latched at 0, the FSM SHALL return to IDLE after the window.
REQ-027 sample_valid_o SHALL fall on the clock after a cycle with sample_valid_o=1 and sample_ready_i=1, unless a new load occurs in that same cycle.
REQ-028 stop_i in WARMUP or CONVERT SHALL send the FSM to IDLE on the next clock, set vco_enb_o=1 and discard the partial count; a pending sample_o/sample_valid_o SHALL be retained.
REQ-029 stop_i and start_i in the same cycle: stop_i SHALL win; in IDLE, the pair SHALL have no effect.
REQ-030 start_i while busy_o=1 SHALL be ignored.
REQ-031 clr_overrun_i SHALL clear overrun_o; if an overrun occurs in the same cycle, set SHALL win.
REQ-032 In IDLE, vco_enb_o SHALL be 1.

Reset
REQ-033 wb_rst_n=0 SHALL immediately force: FSM to IDLE, vco_enb_o=1, sample_o=0, sample_valid_o=0, busy_o=0, overrun_o=0, all counters and synchronizer flops to 0.
REQ-034 Reset asserted mid-run SHALL abort the run with no sample emitted; release SHALL be synchronous to wb_clk_i through the standard reset path.

Structure
REQ-035 Package vco_adc_pkg SHALL hold the FSM state enum and the default CNT_W/OSR_W constants.
REQ-036 The synchronizer and edge detector SHALL be sub-module vco_phase_sync (ports wb_clk_i, wb_rst_n, phase_in, edge_o).

Verification
REQ-037 Stimulus: warmup_i=4, oversample_i=100, cont_i=0, phase toggling every 5 clocks (period 10). Required: vco_enb_o low for 4+100 clocks; one sample with sample_o=10±1; then IDLE with vco_enb_o=1.
REQ-038 Stimulus: cont_i=1, oversample_i=8, phase period 4, sample_ready_i=1. Required: sample_valid_o pulses every 8 clocks, each sample_o=2; no gaps; overrun_o=0.
REQ-039 Stimulus: as REQ-038 but sample_ready_i=0. Required: first sample held; overrun_o=1 at the second window end; clr_overrun_i clears overrun_o, which sets again at the next window.
REQ-040 Stimulus: CNT_W=4, oversample_i=100, phase period 2. Required: sample_o=15 (saturated).
REQ-041 Stimulus: stop_i at CONVERT clock 3, then start_i+stop_i in the same cycle. Required: IDLE next clock, no new sample, vco_enb_o=1, start ignored.
REQ-042 Stimulus: wb_rst_n low mid-CONVERT with sample_valid_o=1. Required: all outputs at reset values immediately; oversample_i=0 on the next run yields 1-clock windows.

Source files
------------

// File: rtl/vco_adc_pkg.sv
// Shared definitions for the VCO ADC sequencer.
//   CNT_W_DEF : default width of the phase-edge counter and of the sample bus
//   OSR_W_DEF : default width of the oversample (window length) input
//   state_t   : sequencer FSM states
package vco_adc_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int OSR_W_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_CONVERT = 2'd2
    } state_t;

endpackage

// File: rtl/vco_adc_seq_if.sv
// Sample output channel of the VCO ADC sequencer (valid/ready handshake).
//   sample_o       : phase-edge count of one window
//   sample_valid_o : sample_o holds an unconsumed count
//   sample_ready_i : consumer accepts sample_o in this cycle
// Modports: master = sequencer side, slave = consumer side.
interface vco_adc_seq_if
    import vco_adc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic [CNT_W-1:0] sample_o;
    logic             sample_valid_o;
    logic             sample_ready_i;

    modport master (
        output sample_o,
        output sample_valid_o,
        input  sample_ready_i
    );

    modport slave (
        input  sample_o,
        input  sample_valid_o,
        output sample_ready_i
    );

endinterface

// File: rtl/vco_phase_sync.sv
// Brings the free-running VCO phase into the wb_clk_i domain and turns each
// rising edge into a single-clock pulse.
//   wb_clk_i : sampling clock
//   wb_rst_n : asynchronous active-low reset, clears every flop
//   phase_in : VCO phase, asynchronous to wb_clk_i
//   edge_o   : one-clock pulse per rising edge of the synchronized phase
module vco_phase_sync (
    input  logic wb_clk_i,
    input  logic wb_rst_n,
    input  logic phase_in,
    output logic edge_o
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic edge_r;

    // Two-flop synchronizer, delayed copy for edge detection, registered pulse
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            edge_r  <= 1'b0;
        end else begin
            sync1_r <= phase_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            edge_r  <= sync2_r & ~prev_r;
        end
    end

    assign edge_o = edge_r;

endmodule

// File: rtl/vco_adc_seq.sv
// VCO-based ADC sequencer: enables the VCO, waits for it to settle, then
// counts synchronized phase edges over fixed-length windows and hands each
// count out over a valid/ready channel.
//   wb_clk_i, wb_rst_n     : clock, asynchronous active-low reset
//   start_i / stop_i       : begin / abort a conversion run (stop wins)
//   cont_i                 : 1 = back-to-back windows, 0 = single window
//   oversample_i           : window length in clocks (0 behaves as 1)
//   warmup_i               : VCO settle time in clocks (0 behaves as 1)
//   phase_in               : VCO phase, asynchronous
//   vco_enb_o              : VCO enable, active-low
//   busy_o                 : sequencer not idle
//   overrun_o/clr_overrun_i: sticky "count dropped" flag and its clear
//   smp                    : sample_o / sample_valid_o / sample_ready_i
module vco_adc_seq
    import vco_adc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int OSR_W = OSR_W_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              cont_i,
    input  logic [OSR_W-1:0]  oversample_i,
    input  logic [7:0]        warmup_i,
    input  logic              phase_in,
    output logic              vco_enb_o,
    output logic              busy_o,
    output logic              overrun_o,
    input  logic              clr_overrun_i,
    vco_adc_seq_if.master     smp
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [OSR_W-1:0] OSR_ZERO = {OSR_W{1'b0}};
    localparam logic [OSR_W-1:0] OSR_ONE  = {{(OSR_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic             edge_s;
    logic             offer_s;
    logic             load_s;
    logic             ovr_set_s;
    logic [CNT_W-1:0] count_inc_s;

    // Terminal counts are stored as "length - 1" so a zero length gives one clock
    logic [OSR_W-1:0] osr_last_r;
    logic [7:0]       warm_last_r;
    logic             cont_r;
    logic [OSR_W-1:0] win_cnt_r;
    logic [7:0]       warm_cnt_r;
    logic [CNT_W-1:0] count_r;

    logic [CNT_W-1:0] sample_r;
    logic             valid_r;
    logic             overrun_r;
    logic             vco_enb_r;
    logic             busy_r;

    vco_phase_sync u_sync (
        .wb_clk_i (wb_clk_i),
        .wb_rst_n (wb_rst_n),
        .phase_in (phase_in),
        .edge_o   (edge_s)
    );

    // Running count including this clock's edge, saturating at all-ones
    always_comb begin
        count_inc_s = count_r;
        if (edge_s && (count_r != CNT_MAX)) begin
            count_inc_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_inc_s = count_r;
        end
    end

    // Next-state logic; offer_s marks the last clock of a window
    always_comb begin
        state_s = state_r;
        offer_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    state_s = ST_WARMUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WARMUP: begin
                if (stop_i) begin
                    state_s = ST_IDLE;
                end else if (warm_cnt_r == warm_last_r) begin
                    state_s = ST_CONVERT;
                end else begin
                    state_s = ST_WARMUP;
                end
            end
            ST_CONVERT: begin
                if (stop_i) begin
                    state_s = ST_IDLE;
                end else if (win_cnt_r == osr_last_r) begin
                    offer_s = 1'b1;
                    state_s = cont_r ? ST_CONVERT : ST_IDLE;
                end else begin
                    state_s = ST_CONVERT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Run configuration capture, warm-up/window timers and edge accumulator
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            osr_last_r  <= OSR_ZERO;
            warm_last_r <= 8'd0;
            cont_r      <= 1'b0;
            win_cnt_r   <= OSR_ZERO;
            warm_cnt_r  <= 8'd0;
            count_r     <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i && !stop_i) begin
                        osr_last_r  <= (oversample_i == OSR_ZERO) ? OSR_ZERO : (oversample_i - OSR_ONE);
                        warm_last_r <= (warmup_i == 8'd0) ? 8'd0 : (warmup_i - 8'd1);
                        cont_r      <= cont_i;
                    end
                    win_cnt_r  <= OSR_ZERO;
                    warm_cnt_r <= 8'd0;
                    count_r    <= {CNT_W{1'b0}};
                end
                ST_WARMUP: begin
                    warm_cnt_r <= warm_cnt_r + 8'd1;
                    win_cnt_r  <= OSR_ZERO;
                    count_r    <= {CNT_W{1'b0}};
                end
                ST_CONVERT: begin
                    // A window end restarts the next window with no gap
                    if (win_cnt_r == osr_last_r) begin
                        win_cnt_r <= OSR_ZERO;
                        count_r   <= {CNT_W{1'b0}};
                    end else begin
                        win_cnt_r <= win_cnt_r + OSR_ONE;
                        count_r   <= count_inc_s;
                    end
                end
                default: begin
                    win_cnt_r  <= OSR_ZERO;
                    warm_cnt_r <= 8'd0;
                    count_r    <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // A count is accepted only if the output register is free or being drained
    assign load_s    = offer_s & (~valid_r | smp.sample_ready_i);
    assign ovr_set_s = offer_s & valid_r & ~smp.sample_ready_i;

    // Output sample register, sticky overrun and registered status outputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sample_r  <= {CNT_W{1'b0}};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
            vco_enb_r <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            if (load_s) begin
                sample_r <= count_inc_s;
                valid_r  <= 1'b1;
            end else if (valid_r && smp.sample_ready_i) begin
                valid_r <= 1'b0;
            end
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (clr_overrun_i) begin
                overrun_r <= 1'b0;
            end
            vco_enb_r <= (state_s == ST_IDLE);
            busy_r    <= (state_s != ST_IDLE);
        end
    end

    assign smp.sample_o       = sample_r;
    assign smp.sample_valid_o = valid_r;
    assign overrun_o          = overrun_r;
    assign vco_enb_o          = vco_enb_r;
    assign busy_o             = busy_r;

endmodule

// File: tb/tb_vco_adc_seq.sv
// Self-checking bench for vco_adc_seq. Expected window counts come from the
// phase period: a steady edge stream of period P seen over N clocks gives
// between floor(N/P) and ceil(N/P) edges, clipped to the counter maximum.
module tb_vco_adc_seq;

    localparam int CNT_W   = 4;
    localparam int OSR_W   = 10;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        int lo;
        int hi;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic             cont;
    logic             clr_ovr;
    logic             phase;
    logic [OSR_W-1:0] osr;
    logic [7:0]       warm;
    logic             vco_enb;
    logic             busy;
    logic             overrun;

    vco_adc_seq_if #(.CNT_W(CNT_W)) smp_if ();

    vco_adc_seq #(.CNT_W(CNT_W), .OSR_W(OSR_W)) dut (
        .wb_clk_i      (clk),
        .wb_rst_n      (rst_n),
        .start_i       (start),
        .stop_i        (stop),
        .cont_i        (cont),
        .oversample_i  (osr),
        .warmup_i      (warm),
        .phase_in      (phase),
        .vco_enb_o     (vco_enb),
        .busy_o        (busy),
        .overrun_o     (overrun),
        .clr_overrun_i (clr_ovr),
        .smp           (smp_if)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   half_per = 5;
    bit   rand_ready = 1'b0;
    logic ready_fixed = 1'b1;
    int   gap_chk = 0;
    bit   have_prev = 1'b0;
    int   last_cyc = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    // VCO phase: toggles every half_per clocks, offset from the clock edge
    initial begin
        phase = 1'b0;
        forever begin
            repeat (half_per) @(posedge clk);
            #3 phase = ~phase;
        end
    end

    // Consumer ready: fixed level or random backpressure
    initial begin
        smp_if.sample_ready_i = 1'b1;
        forever begin
            @(negedge clk);
            if (rand_ready) smp_if.sample_ready_i = 1'($urandom_range(0, 1));
            else            smp_if.sample_ready_i = ready_fixed;
        end
    end

    task automatic chk_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: every accepted sample is matched against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (rst_n && smp_if.sample_valid_o && smp_if.sample_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got %0d, required no sample", smp_if.sample_o);
                end else begin
                    e = exp_q.pop_front();
                    chk_range("sample", int'(smp_if.sample_o), e.lo, e.hi);
                end
                if (gap_chk != 0) begin
                    if (have_prev) chk_eq("window_spacing", cyc - last_cyc, gap_chk);
                    have_prev = 1'b1;
                    last_cyc  = cyc;
                end
            end
        end
    end

    // Reference: edges of a period-p stream seen in n clocks, with saturation
    task automatic push_exp(input int n, input int p, input int k);
        exp_t e;
        int   ne;
        ne = (n == 0) ? 1 : n;
        e.lo = ne / p;
        e.hi = (ne + p - 1) / p;
        if (e.lo > CNT_MAX) e.lo = CNT_MAX;
        if (e.hi > CNT_MAX) e.hi = CNT_MAX;
        for (int i = 0; i < k; i++) exp_q.push_back(e);
    endtask

    task automatic set_half(input int h);
        half_per = h;
        repeat (4 * h + 10) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk_eq("scoreboard_empty", exp_q.size(), 0);
    endtask

    // One run of k windows; continuous runs are stopped right after window k
    task automatic run(input int w, input int n, input bit c, input int k);
        int we;
        int ne;
        we = (w == 0) ? 1 : w;
        ne = (n == 0) ? 1 : n;
        warm = 8'(w);
        osr  = OSR_W'(n);
        cont = c;
        push_exp(n, 2 * half_per, k);
        pulse_start();
        repeat (we + k * ne) @(negedge clk);
        if (c) pulse_stop();
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0; clr_ovr = 1'b0;
        osr = '0; warm = 8'd0;
        repeat (3) @(negedge clk);
        chk_eq("rst_vco_enb", int'(vco_enb), 1);
        chk_eq("rst_busy", int'(busy), 0);
        chk_eq("rst_overrun", int'(overrun), 0);
        chk_eq("rst_valid", int'(smp_if.sample_valid_o), 0);
        chk_eq("rst_sample", int'(smp_if.sample_o), 0);
        rst_n = 1'b1;
        set_half(5);

        // Single window, warm-up 4, window 100, phase period 10; restart attempt mid-run
        warm = 8'd4; osr = OSR_W'(100); cont = 1'b0;
        push_exp(100, 10, 1);
        pulse_start();
        low = 0;
        for (int i = 0; i < 120; i++) begin
            if (vco_enb == 1'b0) low++;
            start = (i == 50);
            @(negedge clk);
        end
        start = 1'b0;
        chk_eq("vco_enb_low_clocks", low, 104);
        chk_eq("idle_vco_enb", int'(vco_enb), 1);
        chk_eq("idle_busy", int'(busy), 0);
        drain();

        // Continuous windows of 8, phase period 4, always ready
        set_half(2);
        gap_chk = 8; have_prev = 1'b0;
        run(3, 8, 1'b1, 5);
        gap_chk = 0;
        chk_eq("cont_no_overrun", int'(overrun), 0);

        // Continuous windows with the consumer stalled
        ready_fixed = 1'b0;
        repeat (2) @(negedge clk);
        warm = 8'd2; osr = OSR_W'(8); cont = 1'b1;
        push_exp(8, 4, 1);
        pulse_start();
        repeat (2 + 8) @(negedge clk);
        chk_eq("stall_first_valid", int'(smp_if.sample_valid_o), 1);
        chk_eq("stall_first_sample", int'(smp_if.sample_o), 2);
        chk_eq("stall_no_overrun_yet", int'(overrun), 0);
        repeat (8) @(negedge clk);
        chk_eq("stall_overrun_set", int'(overrun), 1);
        chk_eq("stall_sample_held", int'(smp_if.sample_o), 2);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk_eq("stall_overrun_cleared", int'(overrun), 0);
        repeat (7) @(negedge clk);
        chk_eq("stall_overrun_again", int'(overrun), 1);
        pulse_stop();
        chk_eq("stop_busy", int'(busy), 0);
        chk_eq("stop_keeps_valid", int'(smp_if.sample_valid_o), 1);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk_eq("overrun_cleared_idle", int'(overrun), 0);
        ready_fixed = 1'b1;
        drain();

        // Saturation: 50 edges in a 100-clock window into a 4-bit counter
        set_half(1);
        run(1, 100, 1'b0, 1);

        // Stop at convert clock 3, then simultaneous start and stop
        set_half(2);
        warm = 8'd3; osr = OSR_W'(8); cont = 1'b0;
        pulse_start();
        repeat (3 + 2) @(negedge clk);
        pulse_stop();
        chk_eq("abort_busy", int'(busy), 0);
        chk_eq("abort_vco_enb", int'(vco_enb), 1);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk_eq("start_stop_busy", int'(busy), 0);
        chk_eq("start_stop_vco_enb", int'(vco_enb), 1);
        repeat (20) @(negedge clk);
        chk_eq("abort_no_sample", int'(smp_if.sample_valid_o), 0);

        // Reset during convert with a pending sample
        ready_fixed = 1'b0;
        warm = 8'd2; osr = OSR_W'(8); cont = 1'b1;
        pulse_start();
        repeat (2 + 10) @(negedge clk);
        chk_eq("pre_reset_valid", int'(smp_if.sample_valid_o), 1);
        #1 rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_vco_enb", int'(vco_enb), 1);
        chk_eq("mid_rst_busy", int'(busy), 0);
        chk_eq("mid_rst_overrun", int'(overrun), 0);
        chk_eq("mid_rst_valid", int'(smp_if.sample_valid_o), 0);
        chk_eq("mid_rst_sample", int'(smp_if.sample_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ready_fixed = 1'b1;
        set_half(1);
        gap_chk = 1; have_prev = 1'b0;
        run(0, 0, 1'b1, 6);
        gap_chk = 0;

        // Randomized runs
        for (int t = 0; t < 12; t++) begin
            int  h;
            int  w;
            int  n;
            bit  c;
            int  k;
            h = int'($urandom_range(1, 4));
            w = int'($urandom_range(0, 12));
            n = int'($urandom_range(0, 40));
            c = 1'($urandom_range(0, 1));
            k = c ? int'($urandom_range(1, 4)) : 1;
            rand_ready = 1'b0;
            set_half(h);
            rand_ready = !c;
            run(w, n, c, k);
            rand_ready = 1'b0;
        end
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
